axi_rd_arbiter: RTL and testbench

//   Round-robin arbiter merging N_MST upstream AXI4 read requesters (IFU, LSU) onto the core's single
//   io_master AR/R channel, upstream of the AXI SRAM model and SoC bus. One outstanding read burst
//   at a time. The granted requester's R beats are routed back to it only.

---
 rtl/axi_rd_arbiter.sv | 146 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Round-robin arbiter that merges N_MST upstream AXI4 read requesters onto one downstream
//   AR/R channel. Only one read burst is outstanding at a time. The granted requester's address
//   phase is registered and replayed downstream, and its R beats are passed straight back to it.
//   The arbiter counts beats against arlen and flags a sticky error when rlast disagrees.
//
// Ports
//   clock, reset          system clock; synchronous active-high reset
//   s_ar*                 per-requester AR channel (payloads packed, slice i = requester i)
//   s_rvalid / s_rready   per-requester R handshake
//   s_rdata / s_rlast     R payload shared by all requesters (qualify with s_rvalid[i])
//   m_ar*                 downstream AR channel (registered payload of the granted requester)
//   m_r*                  downstream R channel
//   err_rlast             sticky flag: rlast disagreed with the beat count

module axi_rd_arbiter #(
  parameter int unsigned N_MST = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_MST-1:0]    s_arvalid,
  output logic [N_MST-1:0]    s_arready,
  input  logic [N_MST*AW-1:0] s_araddr,
  input  logic [N_MST*3-1:0]  s_arsize,
  input  logic [N_MST*8-1:0]  s_arlen,
  input  logic [N_MST*2-1:0]  s_arburst,
  output logic [N_MST-1:0]    s_rvalid,
  input  logic [N_MST-1:0]    s_rready,
  output logic [DW-1:0]       s_rdata,
  output logic                s_rlast,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [AW-1:0]       m_araddr,
  output logic [2:0]          m_arsize,
  output logic [7:0]          m_arlen,
  output logic [1:0]          m_arburst,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DW-1:0]       m_rdata,
  input  logic                m_rlast,
  output logic                err_rlast
);

  localparam int unsigned IdxW = (N_MST > 1) ? $clog2(N_MST) : 1;

  typedef enum logic [1:0] {StIdle, StAr, StRd} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, gnt_q, gnt_idx;
  logic            gnt_valid;
  logic [7:0]      beat_cnt_q;
  logic [AW-1:0]   araddr_q;
  logic [2:0]      arsize_q;
  logic [7:0]      arlen_q;
  logic [1:0]      arburst_q;
  logic            err_q;
  logic            r_hs, last_beat;

  // Scan requesters starting at rr_ptr and wrapping; the first one asserting arvalid wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N_MST; k++) begin
      if (!gnt_valid && s_arvalid[(32'(rr_ptr_q) + k) % N_MST]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'((32'(rr_ptr_q) + k) % N_MST);
      end
    end
  end

  // Handshake routing: ready only in IDLE, R steered to the stored grant only in RD.
  always_comb begin
    s_arready = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    unique case (state_q)
      StIdle: if (gnt_valid) s_arready[gnt_idx] = 1'b1;
      StRd: begin
        s_rvalid[gnt_q] = m_rvalid;
        m_rready        = s_rready[gnt_q];
      end
      default: ;
    endcase
  end

  assign r_hs      = m_rvalid && m_rready;
  assign last_beat = (beat_cnt_q == arlen_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_valid) state_d = StAr;
      StAr:    if (m_arready) state_d = StRd;
      // Burst length is governed by the count, never by rlast.
      StRd:    if (r_hs && last_beat) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
      araddr_q   <= '0;
      arsize_q   <= '0;
      arlen_q    <= '0;
      arburst_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == StIdle && gnt_valid) begin
        araddr_q   <= s_araddr[gnt_idx*AW +: AW];
        arsize_q   <= s_arsize[gnt_idx*3 +: 3];
        arlen_q    <= s_arlen[gnt_idx*8 +: 8];
        arburst_q  <= s_arburst[gnt_idx*2 +: 2];
        gnt_q      <= gnt_idx;
        beat_cnt_q <= '0;
      end
      if (state_q == StRd && r_hs) begin
        if (m_rlast != last_beat) err_q <= 1'b1;
        if (last_beat) begin
          rr_ptr_q <= (gnt_q == IdxW'(N_MST - 1)) ? '0 : gnt_q + 1'b1;
        end else begin
          beat_cnt_q <= beat_cnt_q + 8'd1;
        end
      end
    end
  end

  assign m_arvalid = (state_q == StAr);
  assign m_araddr  = araddr_q;
  assign m_arsize  = arsize_q;
  assign m_arlen   = arlen_q;
  assign m_arburst = arburst_q;
  assign s_rdata   = m_rdata;
  assign s_rlast   = m_rlast;
  assign err_rlast = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
//   Scoreboard bench for axi_rd_arbiter. Requests push expected AR payloads and R beats into
//   queues; a cycle-stepped downstream model answers bursts with data = araddr + beat index,
//   and every observed handshake pops and compares against the queues.

module tb_axi_rd_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*AW-1:0] s_araddr;
  logic [N*3-1:0]  s_arsize;
  logic [N*8-1:0]  s_arlen;
  logic [N*2-1:0]  s_arburst;
  logic [DW-1:0]   s_rdata, m_rdata;
  logic            s_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, err_rlast;
  logic [AW-1:0]   m_araddr;
  logic [2:0]      m_arsize;
  logic [7:0]      m_arlen;
  logic [1:0]      m_arburst;

  always #5 clock = ~clock;

  axi_rd_arbiter #(.N_MST(N), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arsize(s_arsize),
    .s_arlen(s_arlen), .s_arburst(s_arburst), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arsize(m_arsize),
    .m_arlen(m_arlen), .m_arburst(m_arburst), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .err_rlast(err_rlast)
  );

  int checks = 0;
  int failures = 0;

  logic [44:0]   exp_ar_q[$];   // {addr, len, size, burst}
  logic [DW:0]   exp_r0_q[$];   // {last, data} for requester 0
  logic [DW:0]   exp_r1_q[$];
  int            gnt_log[$];
  int            gnt_cyc[$];
  int            last_cyc[N];
  int            delivered[N];
  int            cyc = 0;

  // Downstream model state
  bit            dn_active;
  logic [AW-1:0] dn_addr;
  int            dn_len, dn_beat;
  int            bad_beat = -1;
  int            ar_hold = 0;
  bit            toggle1 = 1'b0;

  task automatic clear_sb();
    exp_ar_q.delete();
    exp_r0_q.delete();
    exp_r1_q.delete();
  endtask

  task automatic issue(input int i, input logic [AW-1:0] addr, input int len,
                       input logic [2:0] size, input logic [1:0] burst);
    logic [DW:0] e;
    s_arvalid[i]            = 1'b1;
    s_araddr[i*AW +: AW]    = addr;
    s_arlen[i*8 +: 8]       = 8'(len);
    s_arsize[i*3 +: 3]      = size;
    s_arburst[i*2 +: 2]     = burst;
    exp_ar_q.push_back({addr, 8'(len), size, burst});
    for (int b = 0; b <= len; b++) begin
      e = {((b == len) || (b == bad_beat)), addr + 32'(b)};
      if (i == 0) exp_r0_q.push_back(e);
      else        exp_r1_q.push_back(e);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then advance the models after the edge.
  task automatic step();
    logic          ar_hs, r_hs;
    logic [AW-1:0] cap_addr;
    int            cap_len;
    logic [N-1:0]  granted;
    logic [DW:0]   got, e;
    @(negedge clock);
    ar_hs    = m_arvalid && m_arready;
    r_hs     = m_rvalid && m_rready;
    cap_addr = m_araddr;
    cap_len  = int'(m_arlen);
    granted  = s_arvalid & s_arready;
    for (int i = 0; i < N; i++) begin
      if (granted[i]) begin
        gnt_log.push_back(i);
        gnt_cyc.push_back(cyc);
      end
    end
    if (ar_hs) begin
      checks++;
      if (exp_ar_q.size() == 0) begin
        failures++;
        $display("FAIL ar_unexpected: got addr=%h with no request pending", m_araddr);
      end else begin
        e = '0;
        if ({m_araddr, m_arlen, m_arsize, m_arburst} !== exp_ar_q[0]) begin
          failures++;
          $display("FAIL ar_payload: got %h expected %h",
                   {m_araddr, m_arlen, m_arsize, m_arburst}, exp_ar_q[0]);
        end
        void'(exp_ar_q.pop_front());
      end
    end
    for (int i = 0; i < N; i++) begin
      if (s_rvalid[i] && s_rready[i]) begin
        checks++;
        got = {s_rlast, s_rdata};
        if ((i == 0 && exp_r0_q.size() == 0) || (i == 1 && exp_r1_q.size() == 0)) begin
          failures++;
          $display("FAIL r_unexpected: req %0d got %h with nothing expected", i, got);
        end else begin
          e = (i == 0) ? exp_r0_q.pop_front() : exp_r1_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL r_beat: req %0d got %h expected %h", i, got, e);
          end
        end
        delivered[i]++;
        if (dn_beat == dn_len) last_cyc[i] = cyc;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (granted[i]) s_arvalid[i] = 1'b0;
    if (ar_hs) begin
      dn_active = 1'b1;
      dn_addr   = cap_addr;
      dn_len    = cap_len;
      dn_beat   = 0;
    end else if (r_hs) begin
      if (dn_beat == dn_len) dn_active = 1'b0;
      else                   dn_beat++;
    end
    m_rvalid = dn_active;
    m_rdata  = dn_addr + 32'(dn_beat);
    m_rlast  = dn_active && ((dn_beat == dn_len) || (dn_beat == bad_beat));
    if (toggle1) s_rready[1] = ~s_rready[1];
    if (ar_hold > 0 && m_arvalid) begin
      m_arready = 1'b0;
      ar_hold--;
    end else begin
      m_arready = (ar_hold == 0);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_ar_q.size() != 0 || exp_r0_q.size() != 0 || exp_r1_q.size() != 0 ||
            s_arvalid != '0 || dn_active) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
      clear_sb();
    end
    #1;
    checks++;
    if ({m_arvalid, s_rvalid} !== 3'b000) begin
      failures++;
      $display("FAIL idle_state: m_arvalid,s_rvalid=%b required 000", {m_arvalid, s_rvalid});
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    s_arvalid = '0;
    s_araddr  = '0;
    s_arsize  = '0;
    s_arlen   = '0;
    s_arburst = '0;
    s_rready  = '1;
    m_arready = 1'b1;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rlast   = 1'b0;
    dn_active = 1'b0;
    dn_beat   = 0;
    dn_len    = 0;
    dn_addr   = '0;
    bad_beat  = -1;
    ar_hold   = 0;
    toggle1   = 1'b0;
    clear_sb();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++;
    if ({m_arvalid, s_arready, s_rvalid, m_rready, err_rlast} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {m_arvalid, s_arready, s_rvalid, m_rready, err_rlast});
    end
    checks++;
    if ({m_araddr, m_arsize, m_arlen, m_arburst} !== 45'b0) begin
      failures++;
      $display("FAIL reset_payload: got %h required 0", {m_araddr, m_arsize, m_arlen, m_arburst});
    end
  endtask

  task automatic test_single_ifu();
    delivered[0] = 0;
    issue(0, 32'h3000_0000, 0, 3'd2, 2'd1);
    #1;
    checks++;
    if ({s_arready, m_arvalid} !== 3'b010) begin
      failures++;
      $display("FAIL single_grant: s_arready,m_arvalid=%b required 010", {s_arready, m_arvalid});
    end
    step();
    #1;
    checks++;
    if ({m_arvalid, s_arready} !== 3'b100 || m_araddr !== 32'h3000_0000) begin
      failures++;
      $display("FAIL single_ar: m_arvalid,s_arready=%b addr=%h required 100 30000000",
               {m_arvalid, s_arready}, m_araddr);
    end
    wait_idle(20);
    checks++;
    if (delivered[0] !== 1 || err_rlast !== 1'b0) begin
      failures++;
      $display("FAIL single_done: beats=%0d err=%b required 1 0", delivered[0], err_rlast);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    gnt_log.delete();
    gnt_cyc.delete();
    issue(0, 32'h0000_1000, 1, 3'd2, 2'd1);
    issue(1, 32'h0000_2000, 0, 3'd2, 2'd1);
    #1;
    checks++;
    if (s_arready !== 2'b01) begin
      failures++;
      $display("FAIL simul_first: s_arready=%b required 01", s_arready);
    end
    wait_idle(40);
    checks++;
    if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 1 ||
        gnt_cyc[1] != last_cyc[0] + 1) begin
      failures++;
      $display("FAIL simul_order: grants=%p cycles=%p ifu_last=%0d required [0,1] at last+1",
               gnt_log, gnt_cyc, last_cyc[0]);
    end
    // A lone IFU read leaves the pointer on LSU, so the next pair must go to LSU first.
    issue(0, 32'h0000_3000, 0, 3'd2, 2'd1);
    wait_idle(20);
    gnt_log.delete();
    issue(1, 32'h0000_4000, 0, 3'd2, 2'd1);
    issue(0, 32'h0000_5000, 0, 3'd2, 2'd1);
    #1;
    checks++;
    if (s_arready !== 2'b10) begin
      failures++;
      $display("FAIL rr_first: s_arready=%b required 10", s_arready);
    end
    wait_idle(40);
    checks++;
    if (gnt_log.size() != 2 || gnt_log[0] != 1 || gnt_log[1] != 0) begin
      failures++;
      $display("FAIL rr_order: grants=%p required [1,0]", gnt_log);
    end
  endtask

  task automatic test_lsu_backpressure();
    delivered[1] = 0;
    toggle1      = 1'b1;
    s_rready[1]  = 1'b1;
    issue(1, 32'h8000_0100, 3, 3'd2, 2'd1);
    wait_idle(60);
    toggle1     = 1'b0;
    s_rready[1] = 1'b1;
    checks++;
    if (delivered[1] !== 4 || err_rlast !== 1'b0) begin
      failures++;
      $display("FAIL lsu_burst: beats=%0d err=%b required 4 0", delivered[1], err_rlast);
    end
  endtask

  task automatic test_ar_stall();
    ar_hold = 5;
    issue(0, 32'h1234_5678, 0, 3'd1, 2'd0);
    step();
    issue(1, 32'h0BAD_F00D, 0, 3'd2, 2'd1);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({m_arvalid, m_araddr, m_arsize, s_arready} !== {1'b1, 32'h1234_5678, 3'd1, 2'b00}) begin
        failures++;
        $display("FAIL ar_stall: cycle %0d arvalid=%b addr=%h size=%0d s_arready=%b", k,
                 m_arvalid, m_araddr, m_arsize, s_arready);
      end
      step();
    end
    wait_idle(40);
  endtask

  task automatic test_bad_rlast();
    delivered[0] = 0;
    bad_beat     = 1;
    issue(0, 32'h0000_A000, 3, 3'd2, 2'd1);
    wait_idle(40);
    checks++;
    if (err_rlast !== 1'b1 || delivered[0] !== 4) begin
      failures++;
      $display("FAIL bad_rlast: err=%b beats=%0d required 1 4", err_rlast, delivered[0]);
    end
    bad_beat = -1;
    issue(1, 32'h0000_B000, 0, 3'd2, 2'd1);
    wait_idle(20);
    checks++;
    if (err_rlast !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: err=%b required 1", err_rlast);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    issue(0, 32'h0000_C000, 0, 3'd2, 2'd1);
    wait_idle(20);
    delivered[1] = 0;
    issue(1, 32'h0000_D000, 3, 3'd2, 2'd1);
    while (delivered[1] < 1 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (n >= 30) begin
      failures++;
      $display("FAIL mid_timeout: no beat after %0d cycles, required at least 1", n);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if ({m_arvalid, m_rready, s_rvalid, s_arready, err_rlast} !== 7'b0) begin
      failures++;
      $display("FAIL mid_reset: arvalid,rready,s_rvalid,s_arready,err=%b required 0",
               {m_arvalid, m_rready, s_rvalid, s_arready, err_rlast});
    end
    dn_active = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    s_arvalid = '0;
    clear_sb();
    reset = 1'b0;
    // The pointer stood on IFU-next before the burst; after reset it must be back at 0.
    issue(0, 32'h0000_E000, 0, 3'd2, 2'd1);
    issue(1, 32'h0000_F000, 0, 3'd2, 2'd1);
    #1;
    checks++;
    if (s_arready !== 2'b01) begin
      failures++;
      $display("FAIL mid_rrptr: s_arready=%b required 01", s_arready);
    end
    wait_idle(40);
  endtask

  initial begin
    last_cyc  = '{default: 0};
    delivered = '{default: 0};
    test_reset();
    test_single_ifu();
    test_simultaneous();
    test_lsu_backpressure();
    test_ar_stall();
    test_bad_rlast();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
